// File: rtl/square_reconstruct_if.sv
// ============================================================================
// Module : square_reconstruct_if
// Brief  : Start/busy/done handshake and operand/result bus for square_reconstruct.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface square_reconstruct_if #(
  parameter int N = 32
);
  logic           start;
  logic [N/2-1:0] root;
  logic [N/2-1:0] remainder;
  logic           busy;
  logic           done;
  logic [N-1:0]   number;
  logic           canonical;

  modport master (
    output start, root, remainder,
    input  busy, done, number, canonical
  );

  modport slave (
    input  start, root, remainder,
    output busy, done, number, canonical
  );
endinterface

`default_nettype wire

// File: rtl/square_reconstruct.sv
// ============================================================================
// Module : square_reconstruct
// Brief  : Rebuilds number = root*root + remainder with a one-bit-per-clock
//          shift-add multiplier; flags canonical pairs (remainder <= 2*root).
//          Optional macro SQUARE_RECONSTRUCT_EARLY_EXIT_EN stops once the
//          remaining multiplier bits are all zero.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module square_reconstruct #(
  parameter int N = 32
) (
  input  wire logic        clk,
  input  wire logic        reset,
  square_reconstruct_if.slave sr
);

  localparam int C_H  = N / 2;
  localparam int C_CW = (C_H > 1) ? $clog2(C_H) : 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(C_H - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic            w_finish;

  logic [N-1:0]    r_acc;
  logic [N-1:0]    r_mcand;
  logic [C_H-1:0]  r_mplier;
  logic [C_CW-1:0] r_count;
  logic            r_canon;
  logic            r_done;
  logic [N-1:0]    r_number;
  logic            r_canonical;

  logic [N-1:0]    w_acc_sum;
  logic [C_H-1:0]  w_mplier_shr;
  logic            w_canon;

  assign w_acc_sum    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_shr = r_mplier >> 1;
  // Both sides at C_H+1 bits so 2*root cannot overflow.
  assign w_canon      = ({1'b0, sr.remainder} <= {sr.root, 1'b0});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sr.start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
`ifdef SQUARE_RECONSTRUCT_EARLY_EXIT_EN
        w_finish = (r_count == C_LAST) || (w_mplier_shr == '0);
`else
        w_finish = (r_count == C_LAST);
`endif
        if (w_finish) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_count     <= '0;
      r_canon     <= 1'b0;
      r_done      <= 1'b0;
      r_number    <= '0;
      r_canonical <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_acc    <= {{(N-C_H){1'b0}}, sr.remainder};
        r_mcand  <= {{(N-C_H){1'b0}}, sr.root};
        r_mplier <= sr.root;
        r_count  <= '0;
        r_canon  <= w_canon;
      end else if (r_state == S_RUN) begin
        r_acc    <= w_acc_sum;
        r_mcand  <= r_mcand << 1;
        r_mplier <= w_mplier_shr;
        r_count  <= r_count + 1'b1;
      end
      if (w_finish) begin
        r_number    <= w_acc_sum;
        r_canonical <= r_canon;
        r_done      <= 1'b1;
      end
    end
  end

  assign sr.busy      = (r_state == S_RUN);
  assign sr.done      = r_done;
  assign sr.number    = r_number;
  assign sr.canonical = r_canonical;

endmodule

`default_nettype wire

// File: tb/tb_square_reconstruct.sv
// ============================================================================
// Module : tb_square_reconstruct
// Brief  : Randomized self-checking bench for square_reconstruct (N=32).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_square_reconstruct;

  localparam int C_N = 32;
  localparam int C_H = C_N / 2;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  square_reconstruct_if #(.N(C_N)) sr_if ();

  square_reconstruct #(.N(C_N)) u_dut (
    .clk   (clk),
    .reset (reset),
    .sr    (sr_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Edges from the accept edge to the edge that raises done.
  function automatic int exp_lat(input logic [15:0] r);
`ifdef SQUARE_RECONSTRUCT_EARLY_EXIT_EN
    int hi;
    hi = 0;
    for (int b = 0; b < C_H; b++) if (r[b]) hi = b;
    return hi + 1;
`else
    return C_H;
`endif
  endfunction

  // Launches one operation and returns at the sample point of the done cycle.
  task automatic do_op(input logic [15:0] r, input logic [15:0] m, input bit disturb);
    logic [31:0] exp_num;
    logic        exp_can;
    int          cycles;
    int          busy_cnt;
    exp_num = 32'(r) * 32'(r) + 32'(m);
    exp_can = (int'(m) <= 2 * int'(r));
    @(negedge clk);
    sr_if.start     = 1'b1;
    sr_if.root      = r;
    sr_if.remainder = m;
    @(posedge clk); #1;
    sr_if.start = 1'b0;
    cycles   = 0;
    busy_cnt = 0;
    while (!sr_if.done && cycles < 100) begin
      if (sr_if.busy) busy_cnt++;
      if (disturb) begin
        sr_if.root      = 16'($urandom);
        sr_if.remainder = 16'($urandom);
        sr_if.start     = 1'($urandom);
      end
      @(posedge clk); #1;
      cycles++;
    end
    sr_if.start = 1'b0;
    chk("done_seen", 64'(sr_if.done), 64'd1);
    chk("latency", 64'(cycles), 64'(exp_lat(r)));
    chk("busy_cycles", 64'(busy_cnt), 64'(exp_lat(r)));
    chk("busy_in_done", 64'(sr_if.busy), 64'd0);
    chk("number", 64'(sr_if.number), 64'(exp_num));
    chk("canonical", 64'(sr_if.canonical), 64'(exp_can));
  endtask

  // One cycle after done: pulse has ended and results are held.
  task automatic post_check();
    logic [31:0] num;
    logic        can;
    num = sr_if.number;
    can = sr_if.canonical;
    @(posedge clk); #1;
    chk("done_pulse", 64'(sr_if.done), 64'd0);
    chk("number_held", 64'(sr_if.number), 64'(num));
    chk("canon_held", 64'(sr_if.canonical), 64'(can));
  endtask

  initial begin
    logic [15:0] r;
    logic [15:0] m;
    n_cmp = 0;
    n_err = 0;
    sr_if.start     = 1'b0;
    sr_if.root      = '0;
    sr_if.remainder = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(sr_if.busy), 64'd0);
    chk("rst_done", 64'(sr_if.done), 64'd0);
    chk("rst_number", 64'(sr_if.number), 64'd0);
    chk("rst_canon", 64'(sr_if.canonical), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(16'h0000, 16'h0000, 1'b0); post_check();
    do_op(16'hFFFF, 16'hFFFF, 1'b0); post_check();
    do_op(16'd3,    16'd7,    1'b0); post_check();
    do_op(16'd3,    16'd6,    1'b0); post_check();
    do_op(16'h04D2, 16'd100,  1'b0); post_check();
    do_op(16'd1,    16'd2,    1'b0); post_check();
    do_op(16'h8000, 16'h1234, 1'b0); post_check();
    do_op(16'h04D2, 16'd100,  1'b1); post_check();

    // Back-to-back: second start lands in the done cycle of the first.
    do_op(16'h1357, 16'h0042, 1'b0);
    do_op(16'h00FF, 16'h01FE, 1'b0); post_check();

    // Reset during RUN cycle 5.
    @(negedge clk);
    sr_if.start = 1'b1; sr_if.root = 16'hABCD; sr_if.remainder = 16'h0011;
    @(posedge clk); #1;
    sr_if.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(sr_if.busy), 64'd0);
    chk("abort_done", 64'(sr_if.done), 64'd0);
    chk("abort_number", 64'(sr_if.number), 64'd0);
    chk("abort_canon", 64'(sr_if.canonical), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (C_H + 4) begin
        @(posedge clk); #1;
        if (sr_if.done) seen++;
      end
      chk("abort_no_done", 64'(seen), 64'd0);
    end
    do_op(16'h0101, 16'h0003, 1'b0); post_check();

    for (int i = 0; i < 24; i++) begin
      r = 16'($urandom) >> $urandom_range(0, 15);
      m = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 2 * int'(r)) & 16'hFFFF);
      do_op(r, m, 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) != 0) post_check();
    end
    post_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/square_reconstruct.md
Name: square_reconstruct

Overview:
- Inverse of the square-root block: takes a (root, remainder) pair and rebuilds number = root*root + remainder.
- Iterative shift-add multiplier with a start/busy/done handshake; one root bit is processed per clock.
- Also flags whether the pair is canonical, i.e. remainder <= 2*root, the form a square-root unit produces.
- Used to cross-check square-root results and to regenerate operands in the arithmetic datapath.

Parameters:
- n, 32, width of the reconstructed number. Must be even and >= 4. root and remainder are n/2 bits wide.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- root  input  n/2  square root operand; captured on an accepted start
- remainder  input  n/2  remainder operand; captured on an accepted start
- busy  output  1  high while the operation is in RUN
- done  output  1  one-cycle pulse when number and canonical are valid
- number  output  n  root*root + remainder; held until the next done
- canonical  output  1  1 when remainder <= 2*root; held with number

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: busy=0, done=0, number=0, canonical=0.
  - Internal: state=IDLE; accumulator, mcand, mplier and count cleared.
  - Assertion mid-operation aborts the operation; no done is produced.
- States: IDLE and RUN.
- IDLE with start=1 (accept edge):
  - acc <= zero-extended remainder to n bits.
  - mcand <= zero-extended root to n bits; mplier <= root; count <= 0.
  - canon_r <= (remainder <= {root,1'b0}), compared at n/2+1 bits with no overflow.
  - state <= RUN; busy <= 1.
- RUN, every edge:
  - If mplier[0]=1, acc <= acc + mcand, computed modulo 2^n.
  - mcand <= mcand << 1; mplier <= mplier >> 1; count <= count + 1.
- Finish: on the edge where count == n/2-1:
  - number <= the final acc value, including this edge's add.
  - canonical <= canon_r; done <= 1; busy <= 0; state <= IDLE.
- Latency: start accepted at edge k gives done high in the cycle after edge k+n/2. For n=32 that is 16 RUN cycles.
- done is high for exactly one cycle. A start seen while done=1 is accepted, because state is already IDLE, so back-to-back throughput is n/2+1 cycles.
- start while busy=1 is ignored. root and remainder are not re-sampled during RUN, so operands may change after acceptance.
- No overflow is possible: the maximum result is (2^(n/2)-1)^2 + 2^(n/2)-1 = 2^n - 2^(n/2), which is below 2^n.
- A non-canonical pair is still reconstructed exactly; only canonical=0 marks it.
- number and canonical change only on a finish edge or on reset.

Optional Feature:
- Macro: SQUARE_RECONSTRUCT_EARLY_EXIT_EN.
- Defined:
  - The finish condition becomes (count == n/2-1) OR (the mplier value after this edge's shift is 0).
  - Zero-valued high root bits are skipped, so latency is (index of the highest set bit of root, plus 1) RUN cycles, with a minimum of 1.
  - root=0 finishes after 1 RUN cycle with number = remainder.
  - Results are identical to the undefined case; only timing differs.
- Undefined: fixed n/2 RUN cycles for every operand.

Test Plan:
- n=32, root=0, remainder=0, start one cycle -> done pulses once, 17 cycles after the start edge (16 RUN cycles then done); number=0x00000000, canonical=1; busy high for exactly 16 cycles.
- root=0xFFFF, remainder=0xFFFF -> number=0xFFFF0000, canonical=1 (0xFFFF <= 0x1FFFE).
- root=3, remainder=7 -> number=0x00000010, canonical=0; root=3, remainder=6 -> number=0x0000000F, canonical=1.
- Operand and handshake checks:
  - root=0x04D2, remainder=100 -> number=0x00173CA8, canonical=1.
  - Change root/remainder and pulse start during RUN -> same result and timing, with no extra done.
  - Pulse start in the done cycle -> second operation accepted, second done 17 cycles later.
- Assert reset at RUN cycle 5 -> busy, done, number and canonical go to 0 immediately; no done follows; the next start completes normally.
- SQUARE_RECONSTRUCT_EARLY_EXIT_EN defined:
  - root=1, remainder=2 -> done after 1 RUN cycle, number=3, canonical=1.
  - root=0x8000 -> full 16 RUN cycles, number=0x40000000 + remainder.
